// File: rtl/mxn_arb_reg_pkg.sv
// mxn_defs: shared definitions for the mxn_arb_reg channel selector and
// the arbiters built on rr_pick_n (mode encoding and channel-count limits).
package mxn_defs;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   localparam int CH_MIN = 2;
   localparam int CH_MAX = 16;

endpackage

// File: rtl/rr_pick_n.sv
// rr_pick_n: purely combinational round-robin picker. Returns the first
// asserted request found searching upward from ptr, wrapping CH-1 -> 0.
module rr_pick_n
   import mxn_defs::*;
#(
   parameter  int CH    = 4,
   localparam int SEL_W = $clog2(CH)
) (
   input  logic [CH-1:0]    req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt
);

   // ptr + k modulo CH; ptr is always kept below CH by the owner
   function automatic logic [SEL_W-1:0] wrap_add(logic [SEL_W-1:0] p, int k);
      int j;
      j = int'(p) + k;
      if (j >= CH) j = j - CH;
      return SEL_W'(j);
   endfunction

   // scan from farthest to nearest so the nearest requester wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt       = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            gnt_valid = 1'b1;
            gnt       = wrap_add(ptr, k);
         end
      end
   end

endmodule

// File: rtl/mxn_arb_reg.sv
// mxn_arb_reg: CH-to-1 channel selector with a registered output stage and
// valid/ready on every channel. mode selects external select (s) or
// round-robin arbitration. Optional macro MXN_ARB_PARITY_EN adds a
// registered even-parity output out_par.
module mxn_arb_reg
   import mxn_defs::*;
#(
   parameter  int WIDTH = 32,
   parameter  int CH    = 4,
   localparam int SEL_W = $clog2(CH)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CH*WIDTH-1:0] in_data,
   input  logic [CH-1:0]       in_valid,
   output logic [CH-1:0]       in_ready,
   input  logic                mode,
   input  logic [SEL_W-1:0]    s,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SEL_W-1:0]    out_ch
`ifdef MXN_ARB_PARITY_EN
   ,output logic               out_par
`endif
);

   logic             load;
   logic             rr_gnt_valid;
   logic [SEL_W-1:0] rr_gnt;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic             xfer;
   logic [SEL_W-1:0] rr_ptr;
   logic [WIDTH-1:0] sel_data;

   // output register can take a word when empty or being drained this cycle
   assign load = !out_valid | out_ready;

   rr_pick_n #(.CH(CH)) u_pick (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .gnt_valid (rr_gnt_valid),
      .gnt       (rr_gnt)
   );

   // grant selection; an out-of-range s (non power-of-two CH) grants nothing
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      if (mode == MODE_RR) begin
         grant_valid = rr_gnt_valid;
         grant       = rr_gnt;
      end else if ((int'(s) < CH) && in_valid[s]) begin
         grant_valid = 1'b1;
         grant       = s;
      end
   end

   // a grant implies in_valid on that channel, so load & grant is a transfer;
   // nothing is accepted while reset is held
   assign xfer     = reset_n & load & grant_valid;
   assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];

   // one-hot ready toward the granted channel only
   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[grant] = 1'b1;
   end

   // output stage: capture on transfer, drop valid on drain with no grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_ch    <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // round-robin pointer advances past the winner, only on RR transfers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (xfer && (mode == MODE_RR)) begin
         rr_ptr <= (int'(grant) == CH - 1) ? '0 : SEL_W'(grant + 1'b1);
      end
   end

`ifdef MXN_ARB_PARITY_EN
   // even parity of the captured word, loaded alongside out_data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_par <= 1'b0;
      end else if (xfer) begin
         out_par <= ^sel_data;
      end
   end
`endif

endmodule

// File: tb/tb_mxn_arb_reg.sv
// tb_mxn_arb_reg: directed bench for mxn_arb_reg (CH=4, WIDTH=32) with a
// scoreboard of expected output words.
module tb_mxn_arb_reg;

   localparam int WIDTH = 32;
   localparam int CH    = 4;
   localparam int SEL_W = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_ready;
   logic                mode;
   logic [SEL_W-1:0]    s;
   logic [WIDTH-1:0]    out_data;
   logic                out_valid;
   logic                out_ready;
   logic [SEL_W-1:0]    out_ch;
`ifdef MXN_ARB_PARITY_EN
   logic                out_par;
`endif

   mxn_arb_reg #(.WIDTH(WIDTH), .CH(CH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .s         (s),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
`ifdef MXN_ARB_PARITY_EN
      ,.out_par  (out_par)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] cur_base;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // channel i carries base + i
   task automatic set_data(input logic [31:0] base);
      cur_base = base;
      for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = base + 32'(i);
   endtask

   // check ready toward ch and record the word expected on the next edge
   task automatic expect_grant(input int ch, input string tag);
      exp_t e;
      #1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(4'b0001 << ch));
      e.ch   = ch;
      e.data = cur_base + 32'(ch);
      sb.push_back(e);
   endtask

   // advance one cycle and compare any word due at this edge
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b1));
         chk({tag, "_out_data"}, 64'(out_data), 64'(e.data));
         chk({tag, "_out_ch"}, 64'(out_ch), 64'(e.ch));
`ifdef MXN_ARB_PARITY_EN
         chk({tag, "_out_par"}, 64'(out_par), 64'(^e.data));
`endif
      end
   endtask

   int rr_seq_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int rr_seq_b[4] = '{1, 3, 1, 3};

   initial begin
      // reset held with random inputs
      reset_n   = 1'b0;
      mode      = 1'($urandom);
      s         = SEL_W'($urandom);
      in_valid  = 4'($urandom);
      out_ready = 1'($urandom);
      for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      cur_base  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);

      // release: first RR grant from ch0
      mode      = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_data(32'h1000_0000);
      reset_n   = 1'b1;
      expect_grant(0, "rst_first");
      tick("rst_first");

      // external select, s=2
      mode     = 1'b0;
      s        = 2'd2;
      in_valid = 4'b0110;
      set_data(32'hA5A5_0000);
      expect_grant(2, "sel2");
      tick("sel2");

      // s=3 not valid: no transfer, output drains
      s        = 2'd3;
      set_data(32'h5555_0000);
      #1;
      chk("sel3_in_ready", 64'(in_ready), 64'd0);
      tick("sel3");
      chk("sel3_drain_valid", 64'(out_valid), 64'd0);
      chk("sel3_hold_data", 64'(out_data), 64'hA5A5_0002);

      // capture 0000_0007 then assert reset asynchronously mid-cycle
      s        = 2'd1;
      in_valid = 4'b0010;
      set_data(32'h0000_0006);
      expect_grant(1, "par");
      tick("par");
      in_valid = 4'b0000;
      out_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_data", 64'(out_data), 64'd0);
`ifdef MXN_ARB_PARITY_EN
      chk("async_rst_par", 64'(out_par), 64'd0);
`endif
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;

      // round-robin fairness, all requesting
      mode     = 1'b1;
      in_valid = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         set_data(32'h2000_0000 + 32'(n << 8));
         expect_grant(rr_seq_a[n], "rr_all");
         tick("rr_all");
      end

      // round-robin, channels 1 and 3 only
      in_valid = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         set_data(32'h3000_0000 + 32'(n << 8));
         expect_grant(rr_seq_b[n], "rr_1010");
         tick("rr_1010");
      end

      // stall: ch1 word held while out_ready is low
      in_valid = 4'b0010;
      set_data(32'h1111_1110);
      expect_grant(1, "stall_load");
      tick("stall_load");
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      set_data(32'h4000_0000);
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         tick("stall");
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", 64'(out_data), 64'h1111_1111);
         chk("stall_ch", 64'(out_ch), 64'd1);
      end
      out_ready = 1'b1;
      expect_grant(2, "stall_release");
      tick("stall_release");

      // RR grants ch3, then switch to select s=0 with no bubble, then back
      set_data(32'h5000_0000);
      expect_grant(3, "sw_rr3");
      tick("sw_rr3");
      mode = 1'b0;
      s    = 2'd0;
      set_data(32'h6000_0000);
      expect_grant(0, "sw_sel0");
      tick("sw_sel0");
      mode = 1'b1;
      s    = 2'd2;
      set_data(32'h7000_0000);
      expect_grant(0, "sw_rr0");
      tick("sw_rr0");

      // drain with nothing requesting
      in_valid = 4'b0000;
      #1;
      chk("drain_in_ready", 64'(in_ready), 64'd0);
      tick("drain");
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_hold_ch", 64'(out_ch), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
